matrix_bus_sched: RTL

- Scheduler and arbiter for the shared LED-driver serial bus (sdi/dclk/le) of the micromatrix panel.
- Three requesters compete for the bus: vsync, config-register writes, and pixel data words.
- Each granted request is serialized into the driver's latch-count protocol. A preactivate sequence is inserted automatically before every config write.
- gclk_en is driven to the GCLK generator so that GCLK is paused during vsync and the post-vsync hold.

---
 rtl/matrix_bus_sched.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_bus_sched.sv
// Bus scheduler for the micromatrix LED driver serial port (sdi/dclk/le).
// Arbitrates vsync > config > pixel and serializes each grant as LE-counted pulses.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   vsync_req/vsync_ack level request, one-cycle done pulse after hold
//   cfg_valid/ready     config word handshake; cfg_data, cfg_latches
//   pix_valid/ready     pixel word handshake; pix_data
//   sdi, dclk, le       registered serial bus to the driver
//   gclk_en             registered, low during vsync pulses and hold
//   busy                scheduler is not idle
module matrix_bus_sched #(
   parameter int PREACT_CLOCKS = 14,
   parameter int VSYNC_CLOCKS  = 3,
   parameter int VSYNC_HOLD    = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync_req,
   output logic        vsync_ack,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [15:0] cfg_data,
   input  logic [3:0]  cfg_latches,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [15:0] pix_data,
   output logic        sdi,
   output logic        dclk,
   output logic        le,
   output logic        gclk_en,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      PREACT,
      SHIFT,
      VSYNC,
      HOLD
   } state_t;

   localparam int HW = (VSYNC_HOLD > 1) ? $clog2(VSYNC_HOLD) : 1;

   localparam logic [4:0] PRE_LAST  = 5'(PREACT_CLOCKS + 1);
   localparam logic [4:0] PRE_LE    = 5'(PREACT_CLOCKS);
   localparam logic [4:0] VS_LAST   = 5'(VSYNC_CLOCKS + 1);
   localparam logic [4:0] VS_LE     = 5'(VSYNC_CLOCKS);
   localparam logic [4:0] SH_LAST   = 5'd15;
   localparam logic [HW-1:0] H_LAST = HW'(VSYNC_HOLD - 1);

   state_t        state_q, state_n;
   logic [4:0]    cnt_q, cnt_n;
   logic          ph_q, ph_n;
   logic [HW-1:0] hcnt_q, hcnt_n;
   logic [15:0]   word_q, word_n;
   logic [3:0]    lat_q, lat_n;

   logic sdi_q, sdi_n;
   logic dclk_q, dclk_n;
   logic le_q, le_n;
   logic gclk_q, gclk_n;
   logic ack_q, ack_n;

   logic idle;

   assign idle      = (state_q == IDLE);
   assign busy      = !idle;
   assign cfg_ready = idle && !vsync_req;
   assign pix_ready = idle && !vsync_req && !cfg_valid;

   assign sdi       = sdi_q;
   assign dclk      = dclk_q;
   assign le        = le_q;
   assign gclk_en   = gclk_q;
   assign vsync_ack = ack_q;

   // Next state and counters. A pulse is ph=0 (dclk low) then
   // ph=1 (dclk high); cnt advances after the high phase.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      ph_n    = ph_q;
      hcnt_n  = hcnt_q;
      word_n  = word_q;
      lat_n   = lat_q;

      unique case (state_q)
         IDLE: begin
            cnt_n  = '0;
            ph_n   = 1'b0;
            hcnt_n = '0;
            if (vsync_req) begin
               state_n = VSYNC;
            end else if (cfg_valid) begin
               state_n = PREACT;
               word_n  = cfg_data;
               lat_n   = cfg_latches;
            end else if (pix_valid) begin
               state_n = SHIFT;
               word_n  = pix_data;
               lat_n   = 4'd1;
            end
         end

         PREACT: begin
            if (!ph_q) begin
               ph_n = 1'b1;
            end else begin
               ph_n = 1'b0;
               if (cnt_q == PRE_LAST) begin
                  state_n = SHIFT;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + 5'd1;
               end
            end
         end

         SHIFT: begin
            if (!ph_q) begin
               ph_n = 1'b1;
            end else begin
               ph_n = 1'b0;
               if (cnt_q == SH_LAST) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + 5'd1;
               end
            end
         end

         VSYNC: begin
            if (!ph_q) begin
               ph_n = 1'b1;
            end else begin
               ph_n = 1'b0;
               if (cnt_q == VS_LAST) begin
                  state_n = HOLD;
                  cnt_n   = '0;
                  hcnt_n  = '0;
               end else begin
                  cnt_n = cnt_q + 5'd1;
               end
            end
         end

         HOLD: begin
            if (hcnt_q == H_LAST) begin
               state_n = IDLE;
            end else begin
               hcnt_n = hcnt_q + 1'b1;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // Bus outputs are registered, so they are decoded from the
   // next-state values: a grant at cycle T shows on the bus at T+1.
   always_comb begin
      sdi_n  = 1'b0;
      dclk_n = 1'b0;
      le_n   = 1'b0;
      gclk_n = 1'b1;
      ack_n  = 1'b0;

      unique case (state_n)
         PREACT: begin
            dclk_n = ph_n;
            le_n   = (cnt_n != 5'd0) && (cnt_n <= PRE_LE);
         end

         SHIFT: begin
            dclk_n = ph_n;
            sdi_n  = word_n[~cnt_n[3:0]];
            // le on the last lat_n bits: cnt + lat carries past 15
            le_n   = ({1'b0, cnt_n[3:0]} + {1'b0, lat_n}) > 5'd15;
         end

         VSYNC: begin
            dclk_n = ph_n;
            le_n   = (cnt_n != 5'd0) && (cnt_n <= VS_LE);
            gclk_n = 1'b0;
         end

         HOLD: begin
            gclk_n = 1'b0;
            ack_n  = (hcnt_n == H_LAST);
         end

         default: begin
            sdi_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ph_q    <= 1'b0;
         hcnt_q  <= '0;
         word_q  <= '0;
         lat_q   <= '0;
         sdi_q   <= 1'b0;
         dclk_q  <= 1'b0;
         le_q    <= 1'b0;
         gclk_q  <= 1'b1;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         ph_q    <= ph_n;
         hcnt_q  <= hcnt_n;
         word_q  <= word_n;
         lat_q   <= lat_n;
         sdi_q   <= sdi_n;
         dclk_q  <= dclk_n;
         le_q    <= le_n;
         gclk_q  <= gclk_n;
         ack_q   <= ack_n;
      end
   end

endmodule
